// File: rtl/alu_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: RV32M funct3 codes,
// control FSM states and fast-path result selectors.
// Pure declarations; no latency or flow-control behaviour of its own.
package alu_muldiv_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Result selected when an op bypasses the iteration entirely
    typedef enum logic [1:0] {
        FP_NONE     = 2'd0,
        FP_ALL_ONES = 2'd1,
        FP_OPR1     = 2'd2,
        FP_ZERO     = 2'd3
    } fastpath_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as two's complement for these ops
    function automatic logic opr1_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as two's complement for these ops
    function automatic logic opr2_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iteration datapath: shift/add multiply and restoring divide on unsigned magnitudes.
// One iteration per step pulse; hi_nxt/lo_nxt show the post-step value combinationally.
// No flow control: the owner decides when to load and step. Divide logic present only with ALU_MULDIV_DIV_EN.
module muldiv_iter_core
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
`ifdef ALU_MULDIV_DIV_EN
    input  logic            is_div,
`endif
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] mcand_in,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    // acc: product high half / partial remainder
    // lo : multiplier shifting out, product low half shifting in / dividend shifting out, quotient shifting in
    // mcand: multiplicand / divisor
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;

    logic [XLEN:0]   mul_sum;
`ifdef ALU_MULDIV_DIV_EN
    logic [XLEN:0]   div_rem;
    logic [XLEN:0]   div_diff;
`endif

    // One iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide
    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        hi_nxt  = mul_sum[XLEN:1];
        lo_nxt  = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef ALU_MULDIV_DIV_EN
        div_rem  = {acc_q, lo_q[XLEN-1]};
        div_diff = div_rem - {1'b0, mcand_q};
        if (is_div) begin
            // borrow out of the top bit means the divisor did not fit: restore
            if (!div_diff[XLEN]) begin
                hi_nxt = div_diff[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = div_rem[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    // Next-state for the datapath registers: load clears the accumulator
    always_comb begin
        acc_d   = acc_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        if (load) begin
            acc_d   = '0;
            lo_d    = lo_in;
            mcand_d = mcand_in;
        end else if (step) begin
            acc_d   = hi_nxt;
            lo_d    = lo_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
        end else begin
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// RV32M multiply/divide unit with valid/ready handshake on both sides; divide ops built only with ALU_MULDIV_DIV_EN.
// Latency: out_valid on the (XLEN+1)th cycle after accept; 1 cycle for divide fast paths (and all divides when disabled).
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE and during flush; flush aborts anything.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opr1,
    input  logic [XLEN-1:0] opr2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            err
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
`ifdef ALU_MULDIV_DIV_EN
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            err_q, err_d;
    logic            init_q, init_d;

    logic            s1, s2, neg_in;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN-1:0] core_lo_in, core_mcand_in;
    fastpath_e       fp_sel;
    logic            fp_err;
    logic [XLEN-1:0] fp_res;

    logic            core_load, core_step;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
`ifdef ALU_MULDIV_DIV_EN
    logic [XLEN-1:0] quo_fix, rem_fix;
`endif
    logic [XLEN-1:0] calc_res;

    // init_q keeps in_ready low until the first edge after reset release
    assign in_ready  = init_q && (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign err       = err_q;

    // Request decode: operand magnitudes, result sign and fast-path selection
    always_comb begin
        s1     = opr1_signed(op) && opr1[XLEN-1];
        s2     = opr2_signed(op) && opr2[XLEN-1];
        mag1   = s1 ? -opr1 : opr1;
        mag2   = s2 ? -opr2 : opr2;
        // remainder follows the dividend; products and quotients follow the sign xor
        neg_in = (op == OP_REM) ? s1 : (s1 ^ s2);
        if (is_div_op(op)) begin
            core_lo_in    = mag1;
            core_mcand_in = mag2;
        end else begin
            core_lo_in    = mag2;
            core_mcand_in = mag1;
        end
        fp_sel = FP_NONE;
        fp_err = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
        if (is_div_op(op)) begin
            if (opr2 == '0) begin
                fp_sel = ((op == OP_DIV) || (op == OP_DIVU)) ? FP_ALL_ONES : FP_OPR1;
            end else if ((opr1 == XMIN) && (opr2 == '1)) begin
                if (op == OP_DIV) begin
                    fp_sel = FP_OPR1;
                end else if (op == OP_REM) begin
                    fp_sel = FP_ZERO;
                end
            end
        end
`else
        if (is_div_op(op)) begin
            fp_sel = FP_ALL_ONES;
            fp_err = 1'b1;
        end
`endif
        case (fp_sel)
            FP_ALL_ONES: fp_res = '1;
            FP_OPR1:     fp_res = opr1;
            default:     fp_res = '0;
        endcase
    end

    // Final-cycle sign correction applied to the post-step datapath value
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = neg_q ? -prod : prod;
`ifdef ALU_MULDIV_DIV_EN
        quo_fix  = neg_q ? -core_lo : core_lo;
        rem_fix  = neg_q ? -core_hi : core_hi;
`endif
        calc_res = '0;
        case (op_q)
            OP_MUL:                       calc_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
`ifdef ALU_MULDIV_DIV_EN
            OP_DIV, OP_DIVU:              calc_res = quo_fix;
            OP_REM, OP_REMU:              calc_res = rem_fix;
`else
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: calc_res = '1;
`endif
            default:                      calc_res = '0;
        endcase
    end

    // Control FSM next-state: accept, iterate XLEN times, hold until consumed; flush wins over everything
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        result_d  = result_q;
        err_d     = err_q;
        init_d    = 1'b1;
        core_load = 1'b0;
        core_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_d = op;
                    if (fp_sel != FP_NONE) begin
                        state_d  = DONE;
                        result_d = fp_res;
                        err_d    = fp_err;
                    end else begin
                        state_d   = CALC;
                        cnt_d     = '0;
                        neg_d     = neg_in;
                        err_d     = 1'b0;
                        core_load = 1'b1;
                    end
                end
            end
            CALC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = calc_res;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            err_q    <= err_d;
            init_q   <= init_d;
        end
    end

    muldiv_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
`ifdef ALU_MULDIV_DIV_EN
        .is_div   (op_q[2]),
`endif
        .lo_in    (core_lo_in),
        .mcand_in (core_mcand_in),
        .hi_nxt   (core_hi),
        .lo_nxt   (core_lo)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: vector table for the arithmetic plus hand sequences for
// backpressure, flush and reset. Divide expectations follow ALU_MULDIV_DIV_EN.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_alu_muldiv;

    localparam int XLEN = 32;
    localparam int LAT_ITER = XLEN + 1;

    localparam logic [2:0] T_MUL    = 3'b000;
    localparam logic [2:0] T_MULH   = 3'b001;
    localparam logic [2:0] T_MULHSU = 3'b010;
    localparam logic [2:0] T_MULHU  = 3'b011;
    localparam logic [2:0] T_DIV    = 3'b100;
    localparam logic [2:0] T_DIVU   = 3'b101;
    localparam logic [2:0] T_REM    = 3'b110;
    localparam logic [2:0] T_REMU   = 3'b111;

    typedef struct {
        string           name;
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        logic            err;
        int              lat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = 3'b000;
    logic [XLEN-1:0] opr1 = '0;
    logic [XLEN-1:0] opr2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            err;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .opr1      (opr1),
        .opr2      (opr2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [2:0] o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] r, input logic e, input int l);
        vec_t v;
        v.name = n; v.op = o; v.a = a; v.b = b; v.res = r; v.err = e; v.lat = l;
        tbl.push_back(v);
    endtask

    // Present a request and hold it until accepted; returns 1 unit after the accept edge
    task automatic send(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int w;
        w = 0;
        @(negedge clk);
        op = o; opr1 = a; opr2 = b; in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_at_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_first_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready_after_first_edge", in_ready, 1);

        // ---------------- backpressure: hold DONE for 10 cycles ----------------
        send(T_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_out(lat);
        check("bp_latency", lat, LAT_ITER);
        check("bp_result", result, 32'hFFFF_FFEB);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_result", result, 32'hFFFF_FFEB);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
        end
        take();
        check("bp_after_take_valid", out_valid, 0);
        check("bp_after_take_in_ready", in_ready, 1);

        // ---------------- flush in CALC cycle 5 ----------------
        send(T_MUL, 32'd5, 32'd6);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_calc_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("flush_calc_out_valid", out_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_back_to_idle", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", seen, 0);

        // ---------------- flush beats accept (fast-path op in both builds) ----------------
        @(negedge clk);
        op = T_DIVU; opr1 = 32'd100; opr2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_idle_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_blocks_accept", out_valid, 0);

        // ---------------- reset mid-CALC ----------------
        send(T_MUL, 32'd3, 32'd4);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_calc_out_valid", out_valid, 0);
        check("rst_calc_in_ready", in_ready, 0);
        check("rst_calc_result", result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_calc_in_ready_after", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("rst_calc_no_result", seen, 0);

        // ---------------- reset while a result is waiting ----------------
        send(T_MUL, 32'd9, 32'd9);
        wait_out(lat);
        check("rst_done_result", result, 32'd81);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", out_valid, 0);
        check("rst_done_cleared", result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- vector table ----------------
        add("mul_7_x_m3",      T_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, LAT_ITER);
        add("mul_shift",       T_MUL,    32'h1234_5678,  32'h0000_0010, 32'h2345_6780, 1'b0, LAT_ITER);
        add("mulhu_max",       T_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LAT_ITER);
        add("mulhsu_m1_x_2",   T_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0, LAT_ITER);
        add("mulh_m7_x_3",     T_MULH,   32'hFFFF_FFF9,  32'd3,         32'hFFFF_FFFF, 1'b0, LAT_ITER);
        add("mulh_min_x_min",  T_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, LAT_ITER);
        add("mulh_max_x_max",  T_MULH,   32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0, LAT_ITER);
`ifdef ALU_MULDIV_DIV_EN
        add("div_m7_2",        T_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, LAT_ITER);
        add("rem_m7_2",        T_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, LAT_ITER);
        add("div_7_m2",        T_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, LAT_ITER);
        add("rem_7_m2",        T_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0, LAT_ITER);
        add("divu_100_7",      T_DIVU,   32'd100,        32'd7,         32'd14,        1'b0, LAT_ITER);
        add("remu_100_7",      T_REMU,   32'd100,        32'd7,         32'd2,         1'b0, LAT_ITER);
        add("divu_by_zero",    T_DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF, 1'b0, 1);
        add("remu_by_zero",    T_REMU,   32'd100,        32'd0,         32'd100,       1'b0, 1);
        add("div_overflow",    T_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        add("rem_overflow",    T_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1);
`else
        add("div_disabled",    T_DIV,    32'd10,         32'd2,         32'hFFFF_FFFF, 1'b1, 1);
        add("divu_disabled",   T_DIVU,   32'd100,        32'd7,         32'hFFFF_FFFF, 1'b1, 1);
        add("rem_disabled",    T_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b1, 1);
        add("remu_disabled",   T_REMU,   32'd100,        32'd0,         32'hFFFF_FFFF, 1'b1, 1);
`endif
        add("mul_after_div",   T_MUL,    32'd3,          32'd5,         32'd15,        1'b0, LAT_ITER);

        foreach (tbl[i]) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_out(lat);
            check({tbl[i].name, "_latency"}, lat, tbl[i].lat);
            check({tbl[i].name, "_result"}, result, tbl[i].res);
            check({tbl[i].name, "_err"}, err, tbl[i].err);
            take();
            check({tbl[i].name, "_released"}, out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, 32, operand/result width; legal values are even and >= 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have ports opr1, opr2  input  XLEN  rs1 and rs2 operand values.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  XLEN  operation result.
REQ-012 SHALL have port err  output  1  qualified by out_valid; op not supported in this build.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; in_ready = (state==IDLE) && !flush.
REQ-014 SHALL accept a request on a rising edge with in_valid && in_ready, latching op and operands.
REQ-015 SHALL use radix-2 iteration: exactly XLEN cycles in CALC, then DONE; out_valid is high from the (XLEN+1)th cycle after the accept edge.
REQ-016 SHALL hold result, err and out_valid stable in DONE until out_valid && out_ready, then return to IDLE; next accept is possible no earlier than the following edge.
REQ-017 SHALL compute MUL as the low XLEN bits, and MULH/MULHSU/MULHU as the high XLEN bits of the 2*XLEN product with signed x signed, signed x unsigned, unsigned x unsigned operands.
REQ-018 SHALL compute signed ops on magnitudes and apply sign correction in the final cycle; quotient rounds toward zero, remainder takes the dividend's sign.
REQ-019 SHALL take a fast path IDLE->DONE (out_valid the cycle after accept) for divide-by-zero: DIV/DIVU -> all-ones, REM/REMU -> opr1.
REQ-020 SHALL take the fast path for signed overflow (opr1 = most-negative, opr2 = -1): DIV -> opr1, REM -> 0.
REQ-021 SHALL, on flush in any state, go to IDLE at the next edge with out_valid low; the aborted op produces no result; flush has priority over accept and over the output handshake.
REQ-022 SHALL keep err low for all supported ops.

Reset
REQ-023 SHALL, while rst_n is low, force state IDLE, out_valid 0, err 0, result 0, in_ready 0, and clear all iteration counters and datapath registers.
REQ-024 SHALL abandon any in-flight operation on reset assertion; in_ready rises on the first edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro ALU_MULDIV_DIV_EN defined, support all eight ops as specified above.
REQ-026 SHALL, without ALU_MULDIV_DIV_EN, omit divider hardware; DIV/DIVU/REM/REMU take the fast path with result all-ones and err 1; multiply ops are unchanged.

Structure
REQ-027 SHALL place the op funct3 constants, the state enum and the fast-path result constants in package alu_muldiv_pkg.
REQ-028 SHALL separate the shift/add-subtract iteration datapath into sub-module muldiv_iter_core, with handshake/FSM control in alu_muldiv.

Verification
REQ-029 SHALL cover: MUL 7 x -3 (XLEN=32) -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-030 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIV -7 / 2 -> 0xFFFFFFFD and REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 0 -> 0xFFFFFFFF one cycle after accept.
REQ-032 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 via the fast path; REM of the same operands -> 0.
REQ-033 SHALL cover: out_ready held low 10 cycles in DONE -> result stable, in_ready low; flush at CALC cycle 5 -> IDLE next edge, no out_valid.
REQ-034 SHALL cover: build without ALU_MULDIV_DIV_EN, DIV 10 / 2 -> result 0xFFFFFFFF with err 1 after 1 cycle; rst_n asserted mid-CALC -> out_valid 0 immediately.
